branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the five-stage pipeline. It replaces the fixed "hold IF on every beq/bne" policy with a direct-mapped branch target buffer, where each entry carries a saturating direction counter. The IF stage performs a lookup with the current PC and receives the prediction in the same cycle. The ID stage writes back the resolved outcome of each branch one cycle later.

---
 rtl/branch_predictor.sv | 111 +++++++++++
 tb/tb_branch_predictor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters; zero-latency lookup, one-cycle update.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_mispred,
  input  logic            inv_all,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispreds
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  // MSB-only pattern: the weakly-taken value given to a fresh allocation
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_MAX ^ (CTR_MAX >> 1);
  localparam logic [XLEN-1:0]     PC_STEP  = XLEN'(4);

  logic [ENTRIES-1:0]  validQ;
  logic [TAGW-1:0]     tagQ    [ENTRIES];
  logic [XLEN-1:0]     targetQ [ENTRIES];
  logic [CTR_BITS-1:0] ctrQ    [ENTRIES];

  logic [IDX-1:0]  lkIdx;
  logic [IDX-1:0]  upIdx;
  logic [TAGW-1:0] lkTag;
  logic [TAGW-1:0] upTag;
  logic            lkHit;
  logic            upHit;
  logic            upAccept;

  assign lkIdx = lookup_pc[IDX+1:2];
  assign lkTag = lookup_pc[XLEN-1:IDX+2];
  assign upIdx = update_pc[IDX+1:2];
  assign upTag = update_pc[XLEN-1:IDX+2];

  // Gating with reset keeps predictions quiet before the first clearing edge
  assign lkHit       = reset && validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
  assign pred_hit    = lkHit;
  assign pred_taken  = lkHit && ctrQ[lkIdx][CTR_BITS-1];
  assign pred_target = pred_taken ? targetQ[lkIdx] : (lookup_pc + PC_STEP);

  assign upAccept = reset && update_valid && !inv_all;
  assign upHit    = validQ[upIdx] && (tagQ[upIdx] == upTag);

  always_ff @(posedge clk) begin
    if (!reset || inv_all) begin
      validQ <= '0;
    end else if (upAccept && !upHit && update_taken) begin
      validQ[upIdx] <= 1'b1;
    end
  end

  // Payload is not reset; it is only observable through a set valid bit
  always_ff @(posedge clk) begin
    if (upAccept) begin
      if (upHit) begin
        if (update_taken) begin
          targetQ[upIdx] <= update_target;
          if (ctrQ[upIdx] != CTR_MAX) ctrQ[upIdx] <= ctrQ[upIdx] + 1'b1;
        end else if (ctrQ[upIdx] != '0) begin
          ctrQ[upIdx] <= ctrQ[upIdx] - 1'b1;
        end
      end else if (update_taken) begin
        tagQ[upIdx]    <= upTag;
        targetQ[upIdx] <= update_target;
        ctrQ[upIdx]    <= CTR_WEAK;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] statBranchesQ;
  logic [31:0] statMispredsQ;

  always_ff @(posedge clk) begin
    if (!reset) begin
      statBranchesQ <= '0;
      statMispredsQ <= '0;
    end else if (upAccept) begin
      if (statBranchesQ != 32'hFFFF_FFFF) statBranchesQ <= statBranchesQ + 32'd1;
      if (update_mispred && (statMispredsQ != 32'hFFFF_FFFF)) statMispredsQ <= statMispredsQ + 32'd1;
    end
  end

  assign stat_branches = statBranchesQ;
  assign stat_mispreds = statMispredsQ;

  logic unusedPcBits;
  assign unusedPcBits = ^update_pc[1:0];
`else
  assign stat_branches = 32'h0;
  assign stat_mispreds = 32'h0;

  logic unusedInputs;
  assign unusedInputs = ^{update_mispred, update_pc[1:0]};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default parameters).
// Statistics expectations follow BP_STATS_EN the same way the design does.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispred;
  logic        inv_all;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispreds;

  int nChecks = 0;
  int nPass   = 0;
  int modelBranches = 0;
  int modelMispreds = 0;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CTR_BITS(2)) dut (
    .clk(clk),
    .reset(reset),
    .lookup_pc(lookup_pc),
    .pred_hit(pred_hit),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .update_valid(update_valid),
    .update_pc(update_pc),
    .update_taken(update_taken),
    .update_target(update_target),
    .update_mispred(update_mispred),
    .inv_all(inv_all),
    .stat_branches(stat_branches),
    .stat_mispreds(stat_mispreds)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] statExp(input int v);
`ifdef BP_STATS_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  task automatic expectLookup(input string tag, input logic [31:0] pc,
                              input logic hit, input logic taken, input logic [31:0] target);
    lookup_pc = pc;
    #1;
    checkEq({tag, ".hit"}, {31'b0, pred_hit}, {31'b0, hit});
    checkEq({tag, ".taken"}, {31'b0, pred_taken}, {31'b0, taken});
    checkEq({tag, ".target"}, pred_target, target);
  endtask

  task automatic checkStats(input string tag);
    checkEq({tag, ".branches"}, stat_branches, statExp(modelBranches));
    checkEq({tag, ".mispreds"}, stat_mispreds, statExp(modelMispreds));
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                     input logic mispred);
    @(negedge clk);
    update_valid   = 1'b1;
    update_pc      = pc;
    update_taken   = taken;
    update_target  = target;
    update_mispred = mispred;
    @(posedge clk);
    #1;
    update_valid   = 1'b0;
    update_mispred = 1'b0;
    modelBranches++;
    if (mispred) modelMispreds++;
  endtask

  initial begin
    reset = 1'b0; lookup_pc = 32'h40; update_valid = 1'b0; update_pc = '0;
    update_taken = 1'b0; update_target = '0; update_mispred = 1'b0; inv_all = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    expectLookup("reset", 32'h40, 1'b0, 1'b0, 32'h44);
    checkStats("reset");

    upd(32'h40, 1'b1, 32'h100, 1'b0);
    expectLookup("alloc", 32'h40, 1'b1, 1'b1, 32'h100);

    upd(32'h40, 1'b0, 32'h999, 1'b0);
    expectLookup("dec1", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h999, 1'b0);
    expectLookup("dec2", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    expectLookup("inc1", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    expectLookup("inc2", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    expectLookup("inc3", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h108, 1'b0);
    expectLookup("sat", 32'h40, 1'b1, 1'b1, 32'h108);
    upd(32'h40, 1'b0, 32'h500, 1'b0);
    expectLookup("satdec", 32'h40, 1'b1, 1'b1, 32'h108);
    upd(32'h40, 1'b0, 32'h500, 1'b0);
    expectLookup("satdec2", 32'h40, 1'b1, 1'b0, 32'h44);
    checkStats("afterCtr");

    upd(32'h40, 1'b1, 32'h100, 1'b0);
    expectLookup("realloc", 32'h40, 1'b1, 1'b1, 32'h100);
    // Same-cycle lookup must see pre-update contents
    @(negedge clk);
    update_valid = 1'b1; update_pc = 32'h80; update_taken = 1'b1; update_target = 32'h200;
    expectLookup("sameCycle", 32'h40, 1'b1, 1'b1, 32'h100);
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    modelBranches++;
    expectLookup("evicted", 32'h40, 1'b0, 1'b0, 32'h44);
    expectLookup("alias", 32'h80, 1'b1, 1'b1, 32'h200);
    expectLookup("lowBits", 32'h82, 1'b1, 1'b1, 32'h200);
    upd(32'hC0, 1'b0, 32'h700, 1'b0);
    expectLookup("missNt", 32'hC0, 1'b0, 1'b0, 32'hC4);
    expectLookup("keep80", 32'h80, 1'b1, 1'b1, 32'h200);
    upd(32'h44, 1'b1, 32'h300, 1'b0);
    expectLookup("idx1", 32'h44, 1'b1, 1'b1, 32'h300);
    expectLookup("idx0", 32'h80, 1'b1, 1'b1, 32'h200);

    @(negedge clk);
    inv_all = 1'b1; update_valid = 1'b1; update_pc = 32'h40; update_taken = 1'b1;
    update_target = 32'h900; update_mispred = 1'b1;
    @(posedge clk);
    #1;
    inv_all = 1'b0; update_valid = 1'b0; update_mispred = 1'b0;
    expectLookup("inv40", 32'h40, 1'b0, 1'b0, 32'h44);
    expectLookup("inv80", 32'h80, 1'b0, 1'b0, 32'h84);
    expectLookup("inv44", 32'h44, 1'b0, 1'b0, 32'h48);
    checkStats("inv");

    upd(32'h40, 1'b1, 32'h100, 1'b1);
    expectLookup("postInv", 32'h40, 1'b1, 1'b1, 32'h100);
    checkStats("preReset");

    @(negedge clk);
    reset = 1'b0;
    update_valid = 1'b1; update_pc = 32'h80; update_taken = 1'b1; update_target = 32'h200;
    expectLookup("inReset", 32'h40, 1'b0, 1'b0, 32'h44);
    checkStats("beforeResetEdge");
    repeat (2) @(posedge clk);
    #1;
    update_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    modelBranches = 0;
    modelMispreds = 0;
    checkStats("afterReset");
    expectLookup("rst40", 32'h40, 1'b0, 1'b0, 32'h44);
    expectLookup("rstUpd", 32'h80, 1'b0, 1'b0, 32'h84);

    upd(32'h40, 1'b1, 32'h100, 1'b1);
    upd(32'h40, 1'b0, 32'h000, 1'b0);
    upd(32'h40, 1'b1, 32'h104, 1'b1);
    upd(32'h48, 1'b0, 32'h000, 1'b0);
    upd(32'h48, 1'b1, 32'h180, 1'b0);
    checkEq("stats5.branches", stat_branches, statExp(5));
    checkEq("stats5.mispreds", stat_mispreds, statExp(2));
    expectLookup("final48", 32'h48, 1'b1, 1'b1, 32'h180);
    expectLookup("final40", 32'h40, 1'b1, 1'b1, 32'h104);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
